// File: rtl/seg7_mux_decoder.sv
// Decodes a multiplexed 7-segment bus (tens/ones) into two BCD digits with framing,
// stall-based lock detection and an optional repeat-match glitch filter (SEG7_DEC_FILTER_EN).
module seg7_mux_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] seg_in,
  output logic [3:0] tens_out,
  output logic [3:0] ones_out,
  output logic       valid,
  output logic       err,
  output logic       locked
);

  typedef enum logic {HUNT, TENS} state_t;

  state_t     r_state;
  logic [7:0] r_sq;
  logic       r_sq_vld;
  logic [3:0] r_tens_cand;
  logic [7:0] r_stall;
  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic       r_valid;
  logic       r_err;
  logic       r_locked;

  logic       w_sel;
  logic [3:0] w_digit;
  logic       w_dig_ok;
  logic       w_bad;
  logic       w_done;
  logic       w_accept;
  logic [7:0] w_stall_nxt;

  assign w_sel = r_sq[7];

  always_comb begin
    w_digit  = '0;
    w_dig_ok = 1'b1;
    case (r_sq[6:0])
      7'b0111111: w_digit = 4'd0;
      7'b0000110: w_digit = 4'd1;
      7'b1011011: w_digit = 4'd2;
      7'b1001111: w_digit = 4'd3;
      7'b1100110: w_digit = 4'd4;
      7'b1101101: w_digit = 4'd5;
      7'b1111101: w_digit = 4'd6;
      7'b0000111: w_digit = 4'd7;
      7'b1111111: w_digit = 4'd8;
      7'b1101111: w_digit = 4'd9;
      default:    w_dig_ok = 1'b0;
    endcase
  end

  // r_sq_vld masks the all-zero reset value of r_sq so the first cycle after
  // reset is not decoded as an invalid sample.
  assign w_bad       = r_sq_vld & ~w_dig_ok;
  assign w_done      = r_sq_vld & w_dig_ok & ~w_sel & (r_state == TENS);
  assign w_stall_nxt = (r_stall == 8'hFF) ? 8'hFF : r_stall + 8'd1;

`ifdef SEG7_DEC_FILTER_EN
  logic [3:0] r_cmp_tens;
  logic [3:0] r_cmp_ones;
  logic       r_cmp_vld;

  assign w_accept = r_cmp_vld && (r_cmp_tens == r_tens_cand) && (r_cmp_ones == w_digit);

  always_ff @(posedge clk) begin
    if (reset || w_bad) begin
      r_cmp_tens <= '0;
      r_cmp_ones <= '0;
      r_cmp_vld  <= 1'b0;
    end else if (w_done) begin
      r_cmp_tens <= r_tens_cand;
      r_cmp_ones <= w_digit;
      r_cmp_vld  <= 1'b1;
    end
  end
`else
  assign w_accept = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= HUNT;
      r_sq        <= '0;
      r_sq_vld    <= 1'b0;
      r_tens_cand <= '0;
      r_stall     <= '0;
      r_tens      <= '0;
      r_ones      <= '0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_sq     <= seg_in;
      r_sq_vld <= 1'b1;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;

      if (w_bad) begin
        r_state     <= HUNT;
        r_tens_cand <= '0;
        r_err       <= 1'b1;
      end else if (r_sq_vld) begin
        case (r_state)
          HUNT: begin
            if (w_sel) begin
              r_tens_cand <= w_digit;
              r_state     <= TENS;
            end
          end
          TENS: begin
            if (w_sel) begin
              r_tens_cand <= w_digit;
            end else begin
              r_state <= HUNT;
              if (w_accept) begin
                r_tens  <= r_tens_cand;
                r_ones  <= w_digit;
                r_valid <= 1'b1;
              end
            end
          end
          default: r_state <= HUNT;
        endcase
      end

      r_stall <= w_done ? 8'd0 : w_stall_nxt;

      // Lock drops on the same edge the stall counter lands on 255.
      if (w_bad)
        r_locked <= 1'b0;
      else if (w_done)
        r_locked <= 1'b1;
      else if (w_stall_nxt == 8'hFF)
        r_locked <= 1'b0;
    end
  end

  assign tens_out = r_tens;
  assign ones_out = r_ones;
  assign valid    = r_valid;
  assign err      = r_err;
  assign locked   = r_locked;

endmodule

// File: tb/tb_seg7_mux_decoder.sv
// Directed, table-driven bench for seg7_mux_decoder; adapts expectations to SEG7_DEC_FILTER_EN.
module tb_seg7_mux_decoder;

`ifdef SEG7_DEC_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] seg_in = 8'h00;
  logic [3:0] tens_out;
  logic [3:0] ones_out;
  logic       valid;
  logic       err;
  logic       locked;

  int n_tot = 0;
  int n_bad = 0;

  seg7_mux_decoder dut (
    .clk      (clk),
    .reset    (reset),
    .seg_in   (seg_in),
    .tens_out (tens_out),
    .ones_out (ones_out),
    .valid    (valid),
    .err      (err),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] seg;
    bit         v;
    bit         e;
    int         t;
    int         o;
    bit         l;
    bit         fv;
    int         ft;
    int         fo;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [7:0] s, input bit v, input bit e, input int t, input int o,
                     input bit l, input bit fv, input int ft, input int fo);
    vec_t r;
    r = '{seg: s, v: v, e: e, t: t, o: o, l: l, fv: fv, ft: ft, fo: fo};
    vq.push_back(r);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] enc(input int d);
    logic [6:0] p;
    case (d)
      0: p = 7'b0111111;
      1: p = 7'b0000110;
      2: p = 7'b1011011;
      3: p = 7'b1001111;
      4: p = 7'b1100110;
      5: p = 7'b1101101;
      6: p = 7'b1111101;
      7: p = 7'b0000111;
      8: p = 7'b1111111;
      default: p = 7'b1101111;
    endcase
    return p;
  endfunction

  task automatic step(input logic [7:0] v);
    @(negedge clk);
    seg_in = v;
    @(posedge clk);
    #1;
  endtask

  // Leaves seg_in on a harmless ones-digit so the post-reset idle cycle decodes cleanly.
  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    seg_in = 8'h00;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    seg_in = 8'h3F;
  endtask

  task automatic frame(input int t, input int o, output bit vs, output bit es);
    vs = 1'b0;
    es = 1'b0;
    step({1'b1, enc(t)});
    vs |= valid; es |= err;
    step({1'b0, enc(o)});
    vs |= valid; es |= err;
    step({1'b0, enc(o)});
    vs |= valid; es |= err;
  endtask

  initial begin
    bit vs, es, vseen, eseen;
    vec_t r;

    // seg    v e t o l   fv ft fo
    add(8'hDB, 0,0,0,0,0, 0,0,0);
    add(8'h4F, 0,0,0,0,0, 0,0,0);
    add(8'hDB, 1,0,2,3,1, 0,0,0);
    add(8'h4F, 0,0,2,3,1, 0,0,0);
    add(8'hDB, 1,0,2,3,1, 1,2,3);
    add(8'hC9, 0,0,2,3,1, 0,2,3);
    add(8'h4F, 0,1,2,3,0, 0,2,3);
    add(8'hDB, 0,0,2,3,0, 0,2,3);
    add(8'h4F, 0,0,2,3,0, 0,2,3);
    add(8'hDB, 1,0,2,3,1, 0,2,3);
    add(8'hE6, 0,0,2,3,1, 0,2,3);
    add(8'h4F, 0,0,2,3,1, 0,2,3);
    add(8'h4F, 1,0,4,3,1, 0,2,3);
    add(8'h6D, 0,0,4,3,1, 0,2,3);
    add(8'h00, 0,0,4,3,1, 0,2,3);
    add(8'h00, 0,1,4,3,0, 0,2,3);
    add(8'hED, 0,1,4,3,0, 0,2,3);
    add(8'h6D, 0,0,4,3,0, 0,2,3);
    add(8'h6D, 1,0,5,5,1, 0,2,3);
    add(8'h6D, 0,0,5,5,1, 0,2,3);

    do_reset();
    chk("rst_valid", valid, 0);
    chk("rst_err", err, 0);
    chk("rst_locked", locked, 0);

    for (int i = 0; i < vq.size(); i++) begin
      r = vq[i];
      step(r.seg);
      chk($sformatf("row%0d_valid", i), valid, FILT ? r.fv : r.v);
      chk($sformatf("row%0d_err", i), err, r.e);
      chk($sformatf("row%0d_tens", i), tens_out, FILT ? r.ft : r.t);
      chk($sformatf("row%0d_ones", i), ones_out, FILT ? r.fo : r.o);
      chk($sformatf("row%0d_locked", i), locked, r.l);
    end

    // Reset from a running, locked state must clear everything.
    chk("pre_rst_locked", locked, 1);
    do_reset();
    chk("midrst_tens", tens_out, 0);
    chk("midrst_ones", ones_out, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_valid", valid, 0);

    // Ones digit held alone never forms a frame.
    vseen = 0; eseen = 0;
    for (int i = 0; i < 10; i++) begin
      step(8'h4F);
      vseen |= valid; eseen |= err;
    end
    chk("hold4F_valid", vseen, 0);
    chk("hold4F_err", eseen, 0);
    chk("hold4F_tens", tens_out, 0);
    chk("hold4F_ones", ones_out, 0);
    chk("hold4F_locked", locked, 0);

    // Reset mid-frame discards the pending tens digit.
    do_reset();
    step(8'hDB);
    step(8'hDB);
    @(negedge clk);
    reset  = 1'b1;
    seg_in = 8'h4F;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    vseen = 0;
    for (int i = 0; i < 3; i++) begin
      step(8'h4F);
      vseen |= valid;
    end
    chk("midframe_rst_valid", vseen, 0);
    chk("midframe_rst_tens", tens_out, 0);

    // Frame sequence: 23, 45, 45, reset, 45, 45.
    do_reset();
    frame(2, 3, vs, es);
    chk("f23_valid", vs, FILT ? 0 : 1);
    chk("f23_err", es, 0);
    chk("f23_tens", tens_out, FILT ? 0 : 2);
    chk("f23_ones", ones_out, FILT ? 0 : 3);
    chk("f23_locked", locked, 1);
    frame(4, 5, vs, es);
    chk("f45a_valid", vs, FILT ? 0 : 1);
    chk("f45a_tens", tens_out, FILT ? 0 : 4);
    chk("f45a_ones", ones_out, FILT ? 0 : 5);
    frame(4, 5, vs, es);
    chk("f45b_valid", vs, 1);
    chk("f45b_tens", tens_out, 4);
    chk("f45b_ones", ones_out, 5);
    do_reset();
    frame(4, 5, vs, es);
    chk("f45c_valid", vs, FILT ? 0 : 1);
    chk("f45c_tens", tens_out, FILT ? 0 : 4);
    frame(4, 5, vs, es);
    chk("f45d_valid", vs, 1);
    chk("f45d_tens", tens_out, 4);
    chk("f45d_ones", ones_out, 5);

    // Stall: last completion, then tens held for 300 cycles.
    do_reset();
    step(8'hDB);
    step(8'h4F);
    step(8'hDB);
    step(8'h4F);
    step(8'hDB);
    chk("stall_start_valid", valid, 1);
    chk("stall_start_locked", locked, 1);
    vseen = 0; eseen = 0;
    for (int k = 1; k <= 300; k++) begin
      step(8'hDB);
      vseen |= valid; eseen |= err;
      if (k == 254) chk("stall_254_locked", locked, 1);
      if (k == 255) chk("stall_255_locked", locked, 0);
    end
    chk("stall_valid", vseen, 0);
    chk("stall_err", eseen, 0);
    chk("stall_end_locked", locked, 0);
    chk("stall_tens", tens_out, 2);
    chk("stall_ones", ones_out, 3);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  always @(negedge clk) begin
    if (valid && err) begin
      n_tot++;
      n_bad++;
      $display("FAIL valid_err_overlap: valid=%0b err=%0b expected not both high", valid, err);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time %0t exceeded bound", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg7_mux_decoder.md
SEG7_MUX_DECODER -- requirements
Module: seg7_mux_decoder

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset; all ports are listed below.
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- seg_in  in  8  multiplexed display bus: bit7 = digit select (1 = tens, 0 = ones), bits6:0 = segments g..a.
- tens_out  out  4  last accepted tens digit, BCD.
- ones_out  out  4  last accepted ones digit, BCD.
- valid  out  1  one-cycle pulse when tens_out/ones_out update.
- err  out  1  one-cycle pulse on an undecodable segment sample.
- locked  out  1  level; high while frames arrive regularly.

Function
REQ-002 seg_in SHALL be registered once per cycle (s_q); all decoding SHALL act on s_q only.
REQ-003 Segment decode SHALL be exact-match: 0111111=0, 0000110=1, 1011011=2, 1001111=3, 1100110=4, 1101101=5, 1111101=6, 0000111=7, 1111111=8, 1101111=9; any other pattern, including 0000000, is invalid.
REQ-004 FSM states SHALL be HUNT and TENS; reset state is HUNT.
REQ-005 HUNT: a valid sample with sel=1 SHALL store the tens candidate and go to TENS; a valid sample with sel=0 SHALL be ignored, state HUNT.
REQ-006 TENS: a valid sample with sel=1 SHALL overwrite the tens candidate (latest wins), state TENS.
REQ-007 TENS: a valid sample with sel=0 SHALL complete a frame (tens candidate + this ones digit) and go to HUNT.
REQ-008 On frame completion, tens_out/ones_out SHALL update and valid SHALL pulse high for exactly one cycle, both at the clock edge after the completing sample is registered in s_q (2 edges from seg_in to output).
REQ-009 Between updates, tens_out/ones_out SHALL hold their values; valid SHALL be low.
REQ-010 An invalid sample in either state SHALL discard any partial frame, set the FSM to HUNT, and pulse err for one cycle with the same timing as valid; outputs SHALL hold.
REQ-011 A stall counter (8-bit, saturating at 255) SHALL clear on every frame completion and increment on every other cycle.
REQ-012 locked SHALL set on frame completion and clear when the stall counter reaches 255 or on err; err has priority over a same-cycle completion (not possible by REQ-010, but defined).
REQ-013 valid and err SHALL never be high in the same cycle.

Reset
REQ-014 While reset is high at an edge: s_q=0, FSM=HUNT, tens candidate=0, stall counter=0, tens_out=0, ones_out=0, valid=0, err=0, locked=0.
REQ-015 Reset asserted mid-frame SHALL discard the partial frame; the first post-reset frame SHALL require a fresh sel=1 sample.

Configuration
REQ-016 Macro SEG7_DEC_FILTER_EN SHALL select a glitch filter.
REQ-017 With SEG7_DEC_FILTER_EN defined: a completed frame SHALL update outputs and pulse valid only if its digits equal the immediately previous completed frame; otherwise it becomes the new comparison frame with no update and no valid pulse; err or reset SHALL clear the comparison frame; locked behaviour is unchanged.
REQ-018 Without SEG7_DEC_FILTER_EN: every completed frame updates outputs per REQ-008; no comparison storage exists.

Verification
REQ-019 Reset, then seg_in alternating 8'hDB, 8'h4F each cycle -> first valid 2 edges after the first 8'h4F sample, tens_out=2, ones_out=3, locked=1; valid every 2nd cycle thereafter.
REQ-020 seg_in=8'h4F held 10 cycles after reset -> no valid, no err, outputs 0, locked=0.
REQ-021 After locked "23", inject 8'hC9 (invalid) in place of one 8'hDB -> one err pulse, locked=0, outputs stay 2/3; next 8'hDB,8'h4F pair -> valid, locked=1.
REQ-022 After a completed frame, hold seg_in=8'hDB for 300 cycles -> locked falls 255 cycles after the completion (counter saturation), no valid.
REQ-023 Sequence 8'hDB, 8'hE6 (tens 4), 8'h4F -> tens_out=4, ones_out=3 (latest tens wins).
REQ-024 With SEG7_DEC_FILTER_EN: frames 23, 45, 45 -> no valid on 23 or first 45, valid with 4/5 on second 45; reset asserted between the two 45 frames -> no update until a further matching pair.
